// File: rtl/md_unit_e_if.sv
// md_unit_e_if: EX-stage multiply/divide request/result bundle.
// Signals:
//   start, md_op[2:0], a[31:0], b[31:0] are driven by the master (pipeline).
//   abort is also master-driven, and exists only when MD_ABORT_EN is defined.
//   busy, hi[31:0], lo[31:0] are driven by the slave (md_unit_e).
interface md_unit_e_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
`ifdef MD_ABORT_EN
  logic        abort;
`endif
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, a, b, input busy, hi, lo
`ifdef MD_ABORT_EN
    , output abort
`endif
  );
  modport slave (input start, md_op, a, b, output busy, hi, lo
`ifdef MD_ABORT_EN
    , input abort
`endif
  );
endinterface

// File: rtl/md_unit_e.sv
// md_unit_e: multi-cycle MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO, owning HI/LO.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous, active-low reset
//   m     : md_unit_e_if.slave, carrying start, md_op, a, b, busy, hi, lo (and abort)
// md_op values: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
// Optional feature: define MD_ABORT_EN to enable abort, which cancels an in-flight op with no commit.
module md_unit_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  md_unit_e_if.slave m
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   a_q, a_n, b_q, b_n, hi, hi_n, lo, lo_n;
  logic [1:0]    op_q, op_n;
  logic          abort, start_ok, sgn, na, nb;
  logic [63:0]   ext_a, ext_b, prod, res;
  logic [31:0]   ua, ub, uq, ur, quo, rem;
`ifdef MD_ABORT_EN
  assign abort = m.abort;
`else
  assign abort = 1'b0;
`endif
  // An abort in IDLE also swallows a simultaneous start.
  assign start_ok = m.start && !abort;
  // One 64-bit multiplier serves both MULT and MULTU: the low 64 bits of a
  // product of sign- or zero-extended operands are correct in both cases.
  assign sgn   = ~op_q[0];
  assign ext_a = {{32{sgn & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;
  // Signed division runs on magnitudes, then the signs are restored: the quotient
  // truncates toward zero and the remainder follows the dividend. INT_MIN/-1
  // falls out as 0x80000000 remainder 0.
  assign na  = sgn & a_q[31];
  assign nb  = sgn & b_q[31];
  assign ua  = na ? -a_q : a_q;
  assign ub  = nb ? -b_q : b_q;
  assign uq  = (ub == '0) ? '0 : ua / ub;
  assign ur  = (ub == '0) ? '0 : ua % ub;
  assign quo = (na ^ nb) ? -uq : uq;
  assign rem = na ? -ur : ur;
  assign res = op_q[1] ? {rem, quo} : prod;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    hi_n    = hi;
    lo_n    = lo;
    if (state == IDLE) begin
      if (start_ok && !m.md_op[2]) begin
        state_n = RUN;
        cnt_n   = m.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        a_n     = m.a;
        b_n     = m.b;
        op_n    = m.md_op[1:0];
      end
      hi_n = (start_ok && m.md_op == 3'd4) ? m.a : hi;
      lo_n = (start_ok && m.md_op == 3'd5) ? m.a : lo;
    end else if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      cnt_n = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state_n = IDLE;
        // A divide by zero still burns its full latency but leaves HI/LO alone.
        hi_n = (op_q[1] && b_q == '0) ? hi : res[63:32];
        lo_n = (op_q[1] && b_q == '0) ? lo : res[31:0];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end
  assign m.busy = (state == RUN);
  assign m.hi   = hi;
  assign m.lo   = lo;
endmodule

// File: tb/tb_md_unit_e.sv
// tb_md_unit_e: directed and random scoreboard checks of md_unit_e.
module tb_md_unit_e;
  logic clk = 1'b0;
  logic reset = 1'b0;
  md_unit_e_if m();
  md_unit_e dut (.clk(clk), .reset(reset), .m(m));
  always #5 clk = ~clk;
  int compared = 0;
  int mismatched = 0;
  logic [63:0] sb[$];
  logic [63:0] cur = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
    longint x, y, q, r;
    logic [63:0] p;
    if (op[1] && b == 0) return old;
    x = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    y = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!op[1]) begin
      p = x * y;
      return p;
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    m.start = 1'b1;
    m.md_op = op;
    m.a = a;
    m.b = b;
    @(negedge clk);
    m.start = 1'b0;
  endtask
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n_exp, input bit inj);
    int n;
    logic [63:0] exp;
    sb.push_back(model(op, a, b, cur));
    issue(op, a, b);
    n = 0;
    while (m.busy === 1'b1 && n < 60) begin
      n++;
      if (n == 1) chk({tag, ":hold"}, {m.hi, m.lo}, cur);
      m.start = inj && (n == 1 || n == 2);
      m.md_op = (n == 1) ? 3'd5 : 3'd0;
      m.a = $urandom;
      m.b = $urandom | 32'd1;
      @(negedge clk);
    end
    m.start = 1'b0;
    chk({tag, ":cycles"}, 64'(n), 64'(n_exp));
    exp = sb.pop_front();
    chk({tag, ":result"}, {m.hi, m.lo}, exp);
    cur = exp;
  endtask
  task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    issue(op, a, 32'h0);
    if (op == 3'd4) cur[63:32] = a;
    else if (op == 3'd5) cur[31:0] = a;
    chk({tag, ":busy"}, 64'(m.busy), 64'd0);
    chk({tag, ":hilo"}, {m.hi, m.lo}, cur);
  endtask
  initial begin
    int bad;
    logic [2:0] op;
    m.start = 1'b0;
    m.md_op = '0;
    m.a = '0;
    m.b = '0;
`ifdef MD_ABORT_EN
    m.abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(m.busy), 64'd0);
    chk("reset_hilo", {m.hi, m.lo}, 64'd0);
    reset = 1'b1;
    mt("mthi", 3'd4, 32'hDEADBEEF);
    mt("mtlo", 3'd5, 32'h12345678);
    run_md("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 1'b0);
    chk("mult_const", {m.hi, m.lo}, 64'hFFFFFFFF_FFFFFFFA);
    run_md("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b0);
    chk("multu_const", {m.hi, m.lo}, 64'h00000002_FFFFFFFA);
    run_md("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 1'b0);
    chk("div_const", {m.hi, m.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_md("divu", 3'd3, 32'd7, 32'd2, 10, 1'b0);
    chk("divu_const", {m.hi, m.lo}, 64'h00000001_00000003);
    mt("pre_hi", 3'd4, 32'h11);
    mt("pre_lo", 3'd5, 32'h22);
    run_md("div0", 3'd2, 32'd1234, 32'd0, 10, 1'b0);
    chk("div0_const", {m.hi, m.lo}, 64'h00000011_00000022);
    run_md("intmin", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0);
    chk("intmin_const", {m.hi, m.lo}, 64'h00000000_80000000);
    run_md("inject", 3'd0, 32'h00001234, 32'h00005678, 5, 1'b1);
    chk("inject_const", {m.hi, m.lo}, 64'h00000000_06260060);
    mt("reserved6", 3'd6, 32'hCAFEF00D);
    mt("reserved7", 3'd7, 32'hCAFEF00D);
    for (int i = 0; i < 8; i++) begin
      op = 3'(i % 4);
      run_md($sformatf("rand%0d", i), op, $urandom, (i == 7) ? 32'h0 : $urandom, op[1] ? 10 : 5, 1'b0);
    end
`ifdef MD_ABORT_EN
    issue(3'd0, 32'd5, 32'd7);
    repeat (2) @(negedge clk);
    chk("abort_pre_busy", 64'(m.busy), 64'd1);
    m.abort = 1'b1;
    @(negedge clk);
    m.abort = 1'b0;
    chk("abort_busy", 64'(m.busy), 64'd0);
    chk("abort_hilo", {m.hi, m.lo}, cur);
    run_md("b2b", 3'd0, 32'd5, 32'd7, 5, 1'b0);
    @(negedge clk);
    m.start = 1'b1;
    m.md_op = 3'd4;
    m.a = 32'hBAD0BAD0;
    m.abort = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    m.abort = 1'b0;
    chk("abort_idle", {m.hi, m.lo}, cur);
`endif
    issue(3'd2, 32'd100, 32'd7);
    repeat (6) @(negedge clk);
    chk("rst_pre_busy", 64'(m.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_hilo", {m.hi, m.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (m.busy !== 1'b0 || m.hi !== 32'd0 || m.lo !== 32'd0) bad++;
    end
    chk("rst_no_commit", 64'(bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
